partial_fm_engine: RTL and testbench
====================================

// Module: partial_fm_engine
// PURPOSE
//  Parametrised successor of the fixed 6x6 / 3x3 / three-kernel partial feature-map producer.
//  Convolves one Q1.15 input tile with NUM_K kernels in parallel, one kernel tap per cycle.
//  Adds stride, rounding, saturation, optional ReLU and a start/done handshake.
//  Sits between the tile buffer and the channel accumulator of the conv layer datapath.
// PARAMETERS
//  IP_SIZE  6  input tile side (square)
//  K_SIZE   3  kernel side (square), K_SIZE <= IP_SIZE
//  NUM_K    3  kernels (output channels) processed in parallel
//  STRIDE   1  window step, both axes; OP = (IP_SIZE-K_SIZE)/STRIDE+1 (derived localparam)
//  FRAC     15 fractional bits of the Q format (data 16-bit signed)
//  ROUND    0  0: truncate (arith shift); 1: round half up (add 2^(FRAC-1) before shift)
// PORTS
//  clk      in   1                     clock, rising edge
//  rst      in   1                     async reset, ACTIVE-LOW
//  start    in   1                     begin a tile; sampled only when resting=1
//  relu_en  in   1                     clamp negatives to 0; latched with start
//  ipf      in   16*IP_SIZE*IP_SIZE    input tile, element (r,c) at [16*(r*IP_SIZE+c) +: 16]
//  kf       in   16*NUM_K*K_SIZE*K_SIZE kernel n tap (r,c) at [16*(n*K_SIZE*K_SIZE+r*K_SIZE+c) +: 16]
//  ik       out  16*NUM_K*OP*OP        result n at (r,c) at [16*(n*OP*OP+r*OP+c) +: 16]
//  resting  out  1                     1 = idle, ready for start
//  done     out  1                     one-cycle pulse, final results valid on ik
// BEHAVIOUR
//  Reset (rst=0, any time, async): state=IDLE, ik=0, resting=1, done=0, accumulators/counters=0.
//  Reset mid-tile aborts; no partial results are kept.
//  FSM: IDLE -> LOAD -> MAC -> WRITE -> (MAC | DONE) -> IDLE.
//   IDLE : resting=1. start=1 -> LOAD. relu_en is latched.
//   LOAD : snapshot ipf and kf into internal regs (1 cycle); clear accs; win=(0,0), tap=0.
//          Input changes after this cycle do not affect the tile.
//   MAC  : per cycle, for every n: acc[n] += ip[wr*STRIDE+tr][wc*STRIDE+tc] * k[n][tr][tc].
//          Taps run row-major. After tap K*K-1 -> WRITE.
//   WRITE: per n: s = acc>>>FRAC (ROUND adds 2^(FRAC-1) first); saturate to [-32768,32767];
//          if relu_en then s<0 -> 0. Write s to ik slot (win). Clear accs.
//          Advance win row-major; last window -> DONE, else -> MAC.
//   DONE : done=1 for exactly 1 cycle -> IDLE. ik holds until next LOAD or reset.
//  Products are 32-bit signed. acc width is 32+clog2(K_SIZE*K_SIZE); no internal overflow.
//  ik slots are updated progressively during the tile. Consumers use ik only after done.
//  Latency: start high in IDLE -> done high = 1 + OP*OP*(K_SIZE*K_SIZE+1) + 1 cycles
//  (IP6,K3,S1: 162). resting=0 from LOAD through DONE.
//  start while resting=0 is ignored (no queueing).
//  start held high at DONE -> IDLE for 1 cycle, then a new tile begins.
//  (IP_SIZE-K_SIZE) not divisible by STRIDE: trailing rows/cols are unused.
// TESTING
//  1 Defaults; ipf all 8192; kf ch0=16384, ch1=-8192, ch2=-4096; ROUND=0, relu_en=0
//    -> all ik ch0=32767 (sat from 36864), ch1=-18432, ch2=-9216.
//    done at cycle 162 after start; resting low during the tile.
//  2 Same stimulus with relu_en=1 -> ch0=32767, ch1=0, ch2=0.
//  3 ROUND=1; ipf all 1; all kf 16384 -> every ik=5 (4.5 rounds up).
//    ROUND=0 instance gives 4.
//  4 STRIDE=2, IP=6, K=3; ipf(r,c)=r*6+c (raw); kernel ch0 has center tap 32767, rest 0
//    -> OP=2; ik ch0 = {7,9,19,21} minus truncation (values*32767>>>15: 6,8,18,20).
//  5 Pulse start mid-tile; change ipf after LOAD -> no restart; results match the snapshot.
//  6 Drive rst=0 at cycle 50 of a tile -> ik=0, resting=1 immediately (async).
//    A new start completes normally.

Source files
------------

// File: rtl/partial_fm_engine.sv
// Convolves one Q1.15 tile with NUM_K kernels in parallel, one kernel tap per cycle,
// with stride, rounding, saturation, optional ReLU and a start/done handshake.
module partial_fm_engine #(
    parameter int IP_SIZE = 6,
    parameter int K_SIZE  = 3,
    parameter int NUM_K   = 3,
    parameter int STRIDE  = 1,
    parameter int FRAC    = 15,
    parameter int ROUND   = 0
) (
    input  logic                                                         clk,
    input  logic                                                         rst,
    input  logic                                                         start,
    input  logic                                                         relu_en,
    input  logic [16*IP_SIZE*IP_SIZE-1:0]                                ipf,
    input  logic [16*NUM_K*K_SIZE*K_SIZE-1:0]                            kf,
    output logic [16*NUM_K*((IP_SIZE-K_SIZE)/STRIDE+1)*((IP_SIZE-K_SIZE)/STRIDE+1)-1:0] ik,
    output logic                                                         resting,
    output logic                                                         done
);

    localparam int OP    = (IP_SIZE - K_SIZE) / STRIDE + 1;
    localparam int KK    = K_SIZE * K_SIZE;
    localparam int ACC_W = 32 + $clog2(KK);
    localparam int RW    = (IP_SIZE > 1) ? $clog2(IP_SIZE) : 1;
    localparam int KW    = (K_SIZE > 1) ? $clog2(K_SIZE) : 1;
    localparam int OW    = (OP > 1) ? $clog2(OP) : 1;

    localparam logic signed [ACC_W-1:0] RND_ADD = (ROUND != 0) ? (ACC_W'(1) << (FRAC - 1)) : '0;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        WRITE,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic signed [15:0]      ip_q    [IP_SIZE][IP_SIZE];
    logic signed [15:0]      k_q     [NUM_K][K_SIZE][K_SIZE];
    logic signed [15:0]      ikArr_q [NUM_K][OP][OP];
    logic signed [ACC_W-1:0] acc_q   [NUM_K];
    logic [RW-1:0]           winRow_q, winCol_q, tapRow_q, tapCol_q;
    logic                    reluEn_q;

    logic                    lastTap, lastWin;
    logic [RW-1:0]           ipRow, ipCol;
    logic signed [31:0]      prod    [NUM_K];
    logic signed [15:0]      result  [NUM_K];

    // Shift out the fraction, clamp to 16-bit range, then apply the optional ReLU.
    function automatic logic signed [15:0] scaleResult(input logic signed [ACC_W-1:0] acc,
                                                       input logic relu);
        logic signed [ACC_W-1:0] s;
        s = (acc + RND_ADD) >>> FRAC;
        if (s > SAT_MAX) begin
            s = SAT_MAX;
        end else if (s < SAT_MIN) begin
            s = SAT_MIN;
        end
        if (relu && s[ACC_W-1]) begin
            s = '0;
        end
        return s[15:0];
    endfunction

    assign lastTap = (tapRow_q == RW'(K_SIZE - 1)) && (tapCol_q == RW'(K_SIZE - 1));
    assign lastWin = (winRow_q == RW'(OP - 1)) && (winCol_q == RW'(OP - 1));
    assign ipRow   = RW'(winRow_q * STRIDE) + tapRow_q;
    assign ipCol   = RW'(winCol_q * STRIDE) + tapCol_q;

    always_comb begin
        for (int n = 0; n < NUM_K; n++) begin
            prod[n]   = 32'(ip_q[ipRow][ipCol]) * 32'(k_q[n][tapRow_q[KW-1:0]][tapCol_q[KW-1:0]]);
            result[n] = scaleResult(acc_q[n], reluEn_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        resting = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                resting = 1'b1;
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD:    state_d = MAC;
            MAC:     state_d = lastTap ? WRITE : MAC;
            WRITE:   state_d = lastWin ? DONE : MAC;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The tile snapshot is only ever read after LOAD, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state_q == LOAD) begin
            for (int r = 0; r < IP_SIZE; r++) begin
                for (int c = 0; c < IP_SIZE; c++) begin
                    ip_q[r][c] <= ipf[16*(r*IP_SIZE+c) +: 16];
                end
            end
            for (int n = 0; n < NUM_K; n++) begin
                for (int r = 0; r < K_SIZE; r++) begin
                    for (int c = 0; c < K_SIZE; c++) begin
                        k_q[n][r][c] <= kf[16*(n*KK+r*K_SIZE+c) +: 16];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reluEn_q <= 1'b0;
            winRow_q <= '0;
            winCol_q <= '0;
            tapRow_q <= '0;
            tapCol_q <= '0;
            for (int n = 0; n < NUM_K; n++) begin
                acc_q[n] <= '0;
                for (int r = 0; r < OP; r++) begin
                    for (int c = 0; c < OP; c++) begin
                        ikArr_q[n][r][c] <= '0;
                    end
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        reluEn_q <= relu_en;
                    end
                end
                LOAD: begin
                    winRow_q <= '0;
                    winCol_q <= '0;
                    tapRow_q <= '0;
                    tapCol_q <= '0;
                    for (int n = 0; n < NUM_K; n++) begin
                        acc_q[n] <= '0;
                    end
                end
                MAC: begin
                    for (int n = 0; n < NUM_K; n++) begin
                        acc_q[n] <= acc_q[n] + {{(ACC_W-32){prod[n][31]}}, prod[n]};
                    end
                    if (tapCol_q == RW'(K_SIZE - 1)) begin
                        tapCol_q <= '0;
                        tapRow_q <= (tapRow_q == RW'(K_SIZE - 1)) ? '0 : tapRow_q + 1'b1;
                    end else begin
                        tapCol_q <= tapCol_q + 1'b1;
                    end
                end
                WRITE: begin
                    for (int n = 0; n < NUM_K; n++) begin
                        ikArr_q[n][winRow_q[OW-1:0]][winCol_q[OW-1:0]] <= result[n];
                        acc_q[n] <= '0;
                    end
                    if (winCol_q == RW'(OP - 1)) begin
                        winCol_q <= '0;
                        winRow_q <= (winRow_q == RW'(OP - 1)) ? '0 : winRow_q + 1'b1;
                    end else begin
                        winCol_q <= winCol_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ik = '0;
        for (int n = 0; n < NUM_K; n++) begin
            for (int r = 0; r < OP; r++) begin
                for (int c = 0; c < OP; c++) begin
                    ik[16*(n*OP*OP+r*OP+c) +: 16] = ikArr_q[n][r][c];
                end
            end
        end
    end

endmodule

// File: tb/tb_partial_fm_engine.sv
// Random and directed tiles on two engine configurations, checked against a
// straightforward sum-of-products reference model.
module tb_partial_fm_engine;

    localparam int IP  = 6;
    localparam int K   = 3;
    localparam int NK0 = 3;
    localparam int NK1 = 2;
    localparam int OP0 = 4;
    localparam int OP1 = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start0, start1, relu0, relu1;
    logic [16*IP*IP-1:0]        ipf0, ipf1;
    logic [16*NK0*K*K-1:0]      kf0;
    logic [16*NK1*K*K-1:0]      kf1;
    logic [16*NK0*OP0*OP0-1:0]  ik0;
    logic [16*NK1*OP1*OP1-1:0]  ik1;
    logic                       resting0, resting1, done0, done1;

    int checks = 0;
    int errors = 0;
    int ipM   [IP][IP];
    int kM    [NK0][K][K];
    int expIk [NK0][OP0][OP0];

    always #5 clk = ~clk;

    partial_fm_engine #(.IP_SIZE(6), .K_SIZE(3), .NUM_K(3), .STRIDE(1), .FRAC(15), .ROUND(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .relu_en(relu0), .ipf(ipf0), .kf(kf0),
        .ik(ik0), .resting(resting0), .done(done0)
    );

    partial_fm_engine #(.IP_SIZE(6), .K_SIZE(3), .NUM_K(2), .STRIDE(2), .FRAC(15), .ROUND(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .relu_en(relu1), .ipf(ipf1), .kf(kf1),
        .ik(ik1), .resting(resting1), .done(done1)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int randVal();
        logic [15:0] v;
        v = 16'($urandom());
        case ($urandom_range(0, 3))
            0:       return ($urandom_range(0, 1) == 1) ? 32767 : -32768;
            1:       return $urandom_range(0, 16) - 8;
            default: return int'($signed(v));
        endcase
    endfunction

    function automatic logic getDone(input int which);
        return (which == 0) ? done0 : done1;
    endfunction

    function automatic logic getResting(input int which);
        return (which == 0) ? resting0 : resting1;
    endfunction

    function automatic int ikSlot(input int which, input int n, input int r, input int c);
        if (which == 0) return int'($signed(ik0[16*(n*OP0*OP0+r*OP0+c) +: 16]));
        return int'($signed(ik1[16*(n*OP1*OP1+r*OP1+c) +: 16]));
    endfunction

    task automatic randomTile();
        for (int r = 0; r < IP; r++)
            for (int c = 0; c < IP; c++) ipM[r][c] = randVal();
        for (int n = 0; n < NK0; n++)
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++) kM[n][r][c] = randVal();
    endtask

    task automatic packInputs(input int which);
        for (int r = 0; r < IP; r++)
            for (int c = 0; c < IP; c++)
                if (which == 0) ipf0[16*(r*IP+c) +: 16] = 16'(ipM[r][c]);
                else            ipf1[16*(r*IP+c) +: 16] = 16'(ipM[r][c]);
        for (int n = 0; n < ((which == 0) ? NK0 : NK1); n++)
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    if (which == 0) kf0[16*(n*K*K+r*K+c) +: 16] = 16'(kM[n][r][c]);
                    else            kf1[16*(n*K*K+r*K+c) +: 16] = 16'(kM[n][r][c]);
    endtask

    // Expected feature map: windowed dot product, scale by 2^-15, clamp, optional ReLU.
    task automatic modelTile(input int which, input bit relu);
        int    nk, stride, op;
        bit    rnd;
        longint acc;
        nk     = (which == 0) ? NK0 : NK1;
        stride = (which == 0) ? 1 : 2;
        rnd    = (which != 0);
        op     = (IP - K) / stride + 1;
        for (int n = 0; n < nk; n++)
            for (int r = 0; r < op; r++)
                for (int c = 0; c < op; c++) begin
                    acc = 0;
                    for (int tr = 0; tr < K; tr++)
                        for (int tc = 0; tc < K; tc++)
                            acc += longint'(ipM[r*stride+tr][c*stride+tc]) * longint'(kM[n][tr][tc]);
                    if (rnd) acc += 16384;
                    acc = acc >>> 15;
                    if (acc > 32767)  acc = 32767;
                    if (acc < -32768) acc = -32768;
                    if (relu && acc < 0) acc = 0;
                    expIk[n][r][c] = int'(acc);
                end
    endtask

    task automatic compareTile(input int which, input string name);
        int nk, op;
        nk = (which == 0) ? NK0 : NK1;
        op = (which == 0) ? OP0 : OP1;
        for (int n = 0; n < nk; n++)
            for (int r = 0; r < op; r++)
                for (int c = 0; c < op; c++)
                    checkOutput($sformatf("%s_n%0d_r%0d_c%0d", name, n, r, c),
                                ikSlot(which, n, r, c), expIk[n][r][c]);
    endtask

    // Start a tile and count cycles until done; optionally disturb inputs mid-tile.
    task automatic applyStimulus(input int which, input bit relu, input bit disturb, output int lat);
        if (which == 0) begin relu0 = relu; start0 = 1'b1; end
        else            begin relu1 = relu; start1 = 1'b1; end
        @(posedge clk); #1;
        lat = 1;
        start0 = 1'b0;
        start1 = 1'b0;
        while (getDone(which) == 1'b0 && lat < 400) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 10) checkOutput("resting_mid", int'(getResting(which)), 0);
            if (disturb && lat == 20) begin
                if (which == 0) begin start0 = 1'b1; relu0 = ~relu0; ipf0 = {18{$urandom()}}; kf0 = ~kf0; end
                else            begin start1 = 1'b1; relu1 = ~relu1; ipf1 = {18{$urandom()}}; kf1 = ~kf1; end
            end
            if (disturb && lat == 21) begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
        end
    endtask

    task automatic runAndCheck(input int which, input bit relu, input bit disturb, input string name);
        int lat, op;
        op = (which == 0) ? OP0 : OP1;
        packInputs(which);
        modelTile(which, relu);
        applyStimulus(which, relu, disturb, lat);
        checkOutput({name, "_latency"}, lat, 1 + op*op*(K*K+1) + 1);
        compareTile(which, name);
        @(posedge clk); #1;
        checkOutput({name, "_done_pulse"}, int'(getDone(which)), 0);
        checkOutput({name, "_resting_after"}, int'(getResting(which)), 1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; relu0 = 1'b0; relu1 = 1'b0;
        ipf0 = '0; ipf1 = '0; kf0 = '0; kf1 = '0;
        #2 rst = 1'b0;
        #10;
        checkOutput("rst_ik0", int'(|ik0), 0);
        checkOutput("rst_ik1", int'(|ik1), 0);
        checkOutput("rst_resting0", int'(resting0), 1);
        checkOutput("rst_done0", int'(done0), 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Saturating positive channel, plain negative channels, then the same with ReLU.
        for (int r = 0; r < IP; r++)
            for (int c = 0; c < IP; c++) ipM[r][c] = 8192;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) begin
                kM[0][r][c] = 16384;
                kM[1][r][c] = -8192;
                kM[2][r][c] = -4096;
            end
        runAndCheck(0, 1'b0, 1'b0, "sat");
        checkOutput("sat_ch0_const", ikSlot(0, 0, 0, 0), 32767);
        checkOutput("sat_ch1_const", ikSlot(0, 1, 3, 3), -18432);
        checkOutput("sat_ch2_const", ikSlot(0, 2, 1, 2), -9216);
        runAndCheck(0, 1'b1, 1'b0, "relu");
        checkOutput("relu_ch1_const", ikSlot(0, 1, 0, 0), 0);

        // 4.5 LSB: truncation on dut0, round-half-up on dut1.
        for (int r = 0; r < IP; r++)
            for (int c = 0; c < IP; c++) ipM[r][c] = 1;
        for (int n = 0; n < NK0; n++)
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++) kM[n][r][c] = 16384;
        runAndCheck(0, 1'b0, 1'b0, "trunc");
        checkOutput("trunc_const", ikSlot(0, 0, 2, 1), 4);
        runAndCheck(1, 1'b0, 1'b0, "round");
        checkOutput("round_const", ikSlot(1, 1, 1, 0), 5);

        // Stride 2 with a centre-tap kernel picks out ip(1,1),(1,3),(3,1),(3,3).
        for (int r = 0; r < IP; r++)
            for (int c = 0; c < IP; c++) ipM[r][c] = r*IP + c;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) begin
                kM[0][r][c] = 0;
                kM[1][r][c] = randVal();
            end
        kM[0][1][1] = 32767;
        runAndCheck(1, 1'b0, 1'b0, "stride");
        checkOutput("stride_r0c0", ikSlot(1, 0, 0, 0), 7);
        checkOutput("stride_r1c1", ikSlot(1, 0, 1, 1), 21);

        // Mid-tile start pulse and input changes must not affect the running tile.
        randomTile();
        runAndCheck(0, 1'b0, 1'b1, "disturb");

        // Asynchronous reset during a tile, followed by a clean tile.
        randomTile();
        packInputs(0);
        relu0 = 1'b0;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (49) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("abort_ik0", int'(|ik0), 0);
        checkOutput("abort_resting0", int'(resting0), 1);
        checkOutput("abort_done0", int'(done0), 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        randomTile();
        runAndCheck(0, 1'b1, 1'b0, "after_abort");

        for (int i = 0; i < 5; i++) begin
            randomTile();
            runAndCheck(0, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rnd0_%0d", i));
        end
        for (int i = 0; i < 3; i++) begin
            randomTile();
            runAndCheck(1, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rnd1_%0d", i));
        end

        // Start held through DONE: one idle cycle, then a second tile on the same inputs.
        randomTile();
        packInputs(0);
        modelTile(0, 1'b0);
        relu0 = 1'b0;
        start0 = 1'b1;
        lat = 0;
        while (done0 == 1'b0 && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("hold_latency", lat, 162);
        compareTile(0, "hold_first");
        @(posedge clk); #1;
        checkOutput("hold_idle_gap", int'(resting0), 1);
        @(posedge clk); #1;
        checkOutput("hold_restart", int'(resting0), 0);
        start0 = 1'b0;
        lat = 1;
        while (done0 == 1'b0 && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("hold_second_latency", lat, 162);
        compareTile(0, "hold_second");
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
